// File: rtl/fwd_pkg.sv
// Shared constants and helpers for the forwarding / bypass network.
package fwd_pkg;

    // Operand select encoding: 0 picks the register file, k+1 picks stage k.
    localparam int FW_RF         = 0;
    localparam int FW_STAGE_BASE = 1;

    // Width of the stall-cycle counter.
    localparam int CNT_W = 16;

    // Select width needed to encode "register file" plus every tracked stage.
    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand priority match: finds the youngest producer of the source
// register, flags a load-use hazard and muxes the forwarded operand.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int SEL_W  = sel_w(DEPTH)
) (
    input  logic [DEPTH-1:0]        tag_valid_i,
    input  logic [DEPTH*REG_AW-1:0] tag_rd_i,
    input  logic                    tag_ld0_i,
    input  logic [REG_AW-1:0]       src_rs_i,
    input  logic [DEPTH*DATA_W-1:0] stage_data_i,
    input  logic [DATA_W-1:0]       rf_data_i,
    output logic [SEL_W-1:0]        sel_o,
    output logic [DATA_W-1:0]       data_o,
    output logic                    hazard_o
);

    logic             hit_s;
    logic [SEL_W-1:0] hit_idx_s;

    // Scan oldest to youngest so the lowest matching stage overrides older ones.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (tag_valid_i[k] && (tag_rd_i[k*REG_AW +: REG_AW] == src_rs_i)
                && (src_rs_i != '0)) begin
                hit_s     = 1'b1;
                hit_idx_s = SEL_W'(k);
            end else begin
                hit_s     = hit_s;
                hit_idx_s = hit_idx_s;
            end
        end
    end

    // A load still in stage 0 has no data yet: fall back to the RF and stall.
    always_comb begin
        hazard_o = hit_s && (hit_idx_s == '0) && tag_ld0_i;
        if (hit_s && !hazard_o) begin
            sel_o  = hit_idx_s + SEL_W'(FW_STAGE_BASE);
            data_o = stage_data_i[hit_idx_s*DATA_W +: DATA_W];
        end else begin
            sel_o  = SEL_W'(FW_RF);
            data_o = rf_data_i;
        end
    end

endmodule

// File: rtl/fwd_bypass_net.sv
// Forwarding / bypass network: tracks in-flight destination registers,
// forwards the youngest producer to each consumer operand and requests a
// stall for a load-use dependency on the stage-0 instruction.
module fwd_bypass_net
    import fwd_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int DEPTH   = 3,
    parameter int NUM_OPS = 2,
    parameter int SEL_W   = sel_w(DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      adv_i,
    input  logic                      flush_i,
    input  logic                      wr_en_i,
    input  logic [REG_AW-1:0]         wr_rd_i,
    input  logic                      wr_ld_i,
    input  logic [DEPTH*DATA_W-1:0]   stage_data_i,
    input  logic [NUM_OPS*REG_AW-1:0] src_rs_i,
    input  logic [NUM_OPS*DATA_W-1:0] rf_data_i,
    output logic [NUM_OPS*DATA_W-1:0] op_data_o,
    output logic [NUM_OPS*SEL_W-1:0]  fw_sel_o,
    output logic                      stall_o,
    output logic [CNT_W-1:0]          stall_cnt_o
);

    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [DEPTH*REG_AW-1:0] rd_q, rd_d;
    logic [DEPTH-1:0]        ld_q, ld_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_OPS-1:0]      hazard_s;
    logic                    new_valid_s;

    // One matcher per consumer operand.
    for (genvar j = 0; j < NUM_OPS; j++) begin : g_op
        fwd_match #(
            .DATA_W (DATA_W),
            .REG_AW (REG_AW),
            .DEPTH  (DEPTH),
            .SEL_W  (SEL_W)
        ) u_match (
            .tag_valid_i  (valid_q),
            .tag_rd_i     (rd_q),
            .tag_ld0_i    (ld_q[0]),
            .src_rs_i     (src_rs_i[j*REG_AW +: REG_AW]),
            .stage_data_i (stage_data_i),
            .rf_data_i    (rf_data_i[j*DATA_W +: DATA_W]),
            .sel_o        (fw_sel_o[j*SEL_W +: SEL_W]),
            .data_o       (op_data_o[j*DATA_W +: DATA_W]),
            .hazard_o     (hazard_s[j])
        );
    end

    assign stall_o     = |hazard_s;
    assign stall_cnt_o = cnt_q;
    // r0 writers, flushed and stalled slots all enter as bubbles.
    assign new_valid_s = wr_en_i && (wr_rd_i != '0) && !flush_i && !stall_o;

    // Next state: shift the tag pipeline and bump the saturating stall counter on advance.
    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        ld_d    = ld_q;
        cnt_d   = cnt_q;
        if (adv_i) begin
            valid_d = {valid_q[DEPTH-2:0], new_valid_s};
            rd_d    = {rd_q[(DEPTH-1)*REG_AW-1:0], wr_rd_i};
            ld_d    = {ld_q[DEPTH-2:0], wr_ld_i};
            if (stall_o && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers with synchronous reset overriding advance and flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            rd_q    <= '0;
            ld_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            ld_q    <= ld_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
